plot_arbiter: RTL and testbench
===============================

// Module: plot_arbiter
// PURPOSE
//  Shares the single VGA adapter plot port (x, y, colour, writeEn) among NUM_SRC sprite drawers
//  (obstacle/player animators), each emitting one 8x8 sprite as a BURST_LEN-pixel burst.
//  Round-robin arbitration with burst lock, so each sprite's pixels reach the adapter contiguously.
//  Sits between the animator datapaths and the VGA adapter; one registered output stage.
// PARAMETERS
//  NUM_SRC    4    number of requesting drawers (2..8)
//  BURST_LEN  64   pixels per granted burst (one 8x8 sprite)
//  X_W        8    x coordinate width
//  Y_W        7    y coordinate width
//  C_W        3    colour width
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  reset      in   1              synchronous, active-high reset
//  src_valid  in   NUM_SRC        per-source pixel valid
//  src_ready  out  NUM_SRC        per-source accept; one-hot or zero, combinational from state
//  src_x      in   NUM_SRC*X_W    packed x, source i at [i*X_W +: X_W]
//  src_y      in   NUM_SRC*Y_W    packed y, source i at [i*Y_W +: Y_W]
//  src_colour in   NUM_SRC*C_W    packed colour, source i at [i*C_W +: C_W]
//  x          out  X_W            plot x to VGA adapter (registered)
//  y          out  Y_W            plot y (registered)
//  colour     out  C_W            plot colour (registered)
//  writeEn    out  1              plot strobe, 1 cycle per accepted pixel
//  grant      out  3              index of current/last granted source
//  busy       out  1              1 while in BURST state
// BEHAVIOUR
//  Reset: state=IDLE, src_ready=0, x=0, y=0, colour=0, writeEn=0, grant=NUM_SRC-1, beat count=0, busy=0.
//  States: IDLE, BURST.
//  IDLE: if any src_valid, grant <= first i with src_valid[i], searching (grant+1) mod NUM_SRC upward
//   with wrap; count <= 0; -> BURST. No valid -> stay. src_ready=0 in IDLE.
//  BURST: src_ready[grant]=1, all others 0. Beat = src_valid[grant] & src_ready[grant].
//   On beat: x/y/colour <= granted source fields, writeEn <= 1 next cycle, count <= count+1.
//   No beat: writeEn <= 0; grant held (no timeout, no preemption).
//   Beat with count==BURST_LEN-1: -> IDLE, count <= 0. Exactly BURST_LEN beats per grant.
//  Latency: pixel accepted in cycle N appears on x/y/colour with writeEn=1 in cycle N+1.
//  Bubble: 1 IDLE cycle between bursts (max throughput BURST_LEN/(BURST_LEN+1)).
//  Non-granted valids ignored and never consumed; sources must hold pixel until src_ready.
//  x/y/colour hold last value when writeEn=0.
//  Fairness: after a burst from i, all other requesting sources are granted before i again.
//  Reset mid-burst: burst abandoned, all state to reset values, no writeEn the following cycle.
//  count width = clog2(BURST_LEN); no arithmetic on coordinates (pass-through unless CLIP_EN).
// CONFIGURATION
//  PLOT_ARBITER_CLIP_EN defined: beats with x>159 or y>119 consumed and counted normally, but
//   writeEn stays 0 for that pixel (off-screen clip for sprites wrapping past screen edge).
//  Undefined: every beat produces writeEn=1 regardless of coordinates.
// TESTING
//  1 Reset: reset=1 2 cycles -> writeEn=0, src_ready=0, x=0,y=0,colour=0, busy=0, grant=3.
//  2 Single source: src0 valid continuously, x=10..,y=20 -> busy next cycle, 64 writeEn pulses
//    each 1 cycle after beat, coords match, then 1 idle cycle, re-grant src0.
//  3 Round-robin: src0,src2,src3 valid always -> grant order 0,2,3,0; src1 never readied.
//  4 Stall: drop src_valid[grant] for 5 cycles at beat 30 -> writeEn=0 for 5 cycles, grant held,
//    burst completes after 64 total beats.
//  5 Reset at beat 40 -> next cycle writeEn=0, busy=0; restart grants src0 first with count=0.
//  6 CLIP_EN: src1 burst with x=158..165 -> pixels x=160..165 consumed, writeEn=0; x=158,159 plotted;
//    without macro all 64 plotted.

Source files
------------

// File: rtl/plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing one VGA plot port among sprite drawers.
// Optional PLOT_ARBITER_CLIP_EN suppresses the plot strobe for off-screen pixels.
module plot_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BURST_LEN = 64,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC*X_W-1:0] src_x,
    input  logic [NUM_SRC*Y_W-1:0] src_y,
    input  logic [NUM_SRC*C_W-1:0] src_colour,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   writeEn,
    output logic [2:0]             grant,
    output logic                   busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [2:0] GRANT_RST = 3'(NUM_SRC - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [2:0]       grant_q, grant_nxt;
    logic [2:0]       pick;
    logic             pick_vld;
    int unsigned      rr_idx;
    logic             beat;
    logic             off_screen;
    logic             plot;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;

    // Granted source fields and its handshake
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_c     = '0;
        beat      = 1'b0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_x = src_x[i*X_W +: X_W];
                sel_y = src_y[i*Y_W +: Y_W];
                sel_c = src_colour[i*C_W +: C_W];
                if (state == BURST) begin
                    src_ready[i] = 1'b1;
                    beat         = src_valid[i];
                end
            end
        end
    end

    // First requester after the last grant, wrapping; the last grant itself is checked last
    always_comb begin
        pick     = grant_q;
        pick_vld = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            rr_idx = (int'(grant_q) + k) % NUM_SRC;
            if (!pick_vld && src_valid[rr_idx[2:0]]) begin
                pick     = rr_idx[2:0];
                pick_vld = 1'b1;
            end
        end
    end

`ifdef PLOT_ARBITER_CLIP_EN
    assign off_screen = (32'(sel_x) > 32'd159) || (32'(sel_y) > 32'd119);
`else
    assign off_screen = 1'b0;
`endif

    assign plot = beat && !off_screen;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick;
                    count_nxt = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (beat) begin
                    if (count == LAST) begin
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            grant_q <= GRANT_RST;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            grant_q <= grant_nxt;
        end
    end

    // Clipped pixels leave the plot registers untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
        end else begin
            writeEn <= plot;
            if (plot) begin
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_c;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state == BURST);

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: reset, bursts, round-robin, stall, reset abort, clip.
// Build with +define+PLOT_ARBITER_CLIP_EN to check the clipping variant.
module tb_plot_arbiter;

    localparam int NS = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int BL = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS*XW-1:0] src_x;
    logic [NS*YW-1:0] src_y;
    logic [NS*CW-1:0] src_colour;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CW-1:0]    colour;
    logic             writeEn;
    logic [2:0]       grant;
    logic             busy;

    int tests = 0;
    int fails = 0;

    plot_arbiter #(
        .NUM_SRC(NS), .BURST_LEN(BL), .X_W(XW), .Y_W(YW), .C_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_plot(input int xv, input int yv);
        logic r;
        r = 1'b1;
`ifdef PLOT_ARBITER_CLIP_EN
        if (xv > 159 || yv > 119) r = 1'b0;
`endif
        return r;
    endfunction

    // Entered just after the grant edge; drives BL beats from source g with x = x0+b
    task automatic do_burst(input int g, input int x0, input int stall_at);
        int  ey;
        int  ec;
        int  lx;
        logic pw;
        ey = 20 + g;
        ec = g + 1;
        lx = int'(x);
        chk("grant", 32'(grant), 32'(g));
        chk("busy_start", 32'(busy), 32'd1);
        for (int b = 0; b < BL; b++) begin
            if (b == stall_at) begin
                src_valid[g] = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_we", 32'(writeEn), 32'd0);
                    chk("stall_grant", 32'(grant), 32'(g));
                    chk("stall_x_hold", 32'(x), 32'(lx));
                end
                src_valid[g] = 1'b1;
            end
            chk("ready", 32'(src_ready), 32'(1 << g));
            src_x[g*XW +: XW] = XW'(x0 + b);
            tick();
            pw = exp_plot((x0 + b) % 256, ey);
            chk("we", 32'(writeEn), 32'(pw));
            if (pw) begin
                chk("x", 32'(x), 32'((x0 + b) % 256));
                chk("y", 32'(y), 32'(ey));
                chk("colour", 32'(colour), 32'(ec));
                lx = (x0 + b) % 256;
            end
        end
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_idle", 32'(src_ready), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        src_valid  = '0;
        src_x      = '0;
        src_y      = '0;
        src_colour = '0;
        for (int i = 0; i < NS; i++) begin
            src_y[i*YW +: YW]      = YW'(20 + i);
            src_colour[i*CW +: CW] = CW'(i + 1);
        end

        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(writeEn), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd3);

        // Single source, then one bubble and re-grant
        reset        = 1'b0;
        src_valid    = 4'b0001;
        src_x[0 +: XW] = 8'd10;
        tick();
        do_burst(0, 10, -1);
        chk("bubble_we_last", 32'(writeEn), 32'd1);
        tick();
        chk("bubble_we", 32'(writeEn), 32'd0);

        // Round robin 0,2,3,0 with src1 never served
        src_valid = 4'b1101;
        do_burst(0, 30, -1);
        tick();
        do_burst(2, 50, -1);
        tick();
        do_burst(3, 70, -1);
        tick();
        do_burst(0, 90, -1);

        // Stall at beat 30
        tick();
        do_burst(2, 100, 30);

        // Reset at beat 40
        tick();
        chk("r5_grant", 32'(grant), 32'd3);
        for (int b = 0; b < 40; b++) begin
            src_x[3*XW +: XW] = XW'(b);
            tick();
            chk("r5_we", 32'(writeEn), 32'd1);
        end
        reset = 1'b1;
        tick();
        chk("r5_we_after", 32'(writeEn), 32'd0);
        chk("r5_busy", 32'(busy), 32'd0);
        chk("r5_grant_rst", 32'(grant), 32'd3);
        chk("r5_ready", 32'(src_ready), 32'd0);
        reset = 1'b0;
        tick();
        do_burst(0, 5, -1);

        // Source 1 burst crossing the right screen edge
        src_valid = 4'b0010;
        tick();
        do_burst(1, 158, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
